// File: rtl/button_events.sv
// -----------------------------------------------------------------------------
// button_events
//
// Turns a debounced, already-synchronous button level into discrete events:
// a press pulse, a release pulse, a long-press pulse once the button has been
// held for HOLD_CYCLES clocks, and auto-repeat pulses every REPEAT_CYCLES
// clocks after that. A running 8-bit count of press/long-press/repeat events
// is also kept.
//
// Ports
//   i_clock         system clock, all logic on posedge
//   i_reset         synchronous active-high reset
//   i_clean         debounced button level (1 = pressed)
//   o_press         one-cycle pulse on press
//   o_release       one-cycle pulse on release
//   o_long_press    one-cycle pulse when the hold threshold is reached
//   o_repeat        one-cycle auto-repeat pulse while held
//   o_held          level, high while in the HELD state
//   o_event_count   running count of press, long_press and repeat pulses
// -----------------------------------------------------------------------------
module button_events #(
    parameter int HOLD_CYCLES   = 13_500_000,
    parameter int REPEAT_CYCLES = 2_700_000,
    parameter int CNT_WIDTH     = 24
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_clean,
    output logic       o_press,
    output logic       o_release,
    output logic       o_long_press,
    output logic       o_repeat,
    output logic       o_held,
    output logic [7:0] o_event_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DOWN = 2'd1,
        ST_HELD = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LP_HOLD_LAST   = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] LP_REPEAT_LAST = CNT_WIDTH'(REPEAT_CYCLES - 1);

    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_clean_q;
    logic                 r_press;
    logic                 r_release;
    logic                 r_long_press;
    logic                 r_repeat;
    logic                 r_held;
    logic [7:0]           r_event_count;

    state_t               w_state_nxt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 w_rise;
    logic                 w_press_nxt;
    logic                 w_release_nxt;
    logic                 w_long_nxt;
    logic                 w_rep_nxt;
    logic                 w_evt;

    assign w_rise = i_clean & ~r_clean_q;
    assign w_evt  = w_press_nxt | w_long_nxt | w_rep_nxt;

    // Next-state and pulse decode. A low level in DOWN/HELD is checked before
    // the terminal count so that a release on the terminal edge suppresses
    // the long-press / repeat pulse.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_long_nxt    = 1'b0;
        w_rep_nxt     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (w_rise) begin
                    w_state_nxt = ST_DOWN;
                    w_press_nxt = 1'b1;
                end
            end
            ST_DOWN: begin
                if (!i_clean) begin
                    w_state_nxt   = ST_IDLE;
                    w_cnt_nxt     = '0;
                    w_release_nxt = 1'b1;
                end else if (r_cnt == LP_HOLD_LAST) begin
                    w_state_nxt = ST_HELD;
                    w_cnt_nxt   = '0;
                    w_long_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
                end
            end
            ST_HELD: begin
                if (!i_clean) begin
                    w_state_nxt   = ST_IDLE;
                    w_cnt_nxt     = '0;
                    w_release_nxt = 1'b1;
                end else if (r_cnt == LP_REPEAT_LAST) begin
                    w_cnt_nxt = '0;
                    w_rep_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and registered outputs. During reset clean_q tracks the
    // input so a button held through reset release is not seen as a press.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_clean_q     <= i_clean;
            r_press       <= 1'b0;
            r_release     <= 1'b0;
            r_long_press  <= 1'b0;
            r_repeat      <= 1'b0;
            r_held        <= 1'b0;
            r_event_count <= 8'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_clean_q     <= i_clean;
            r_press       <= w_press_nxt;
            r_release     <= w_release_nxt;
            r_long_press  <= w_long_nxt;
            r_repeat      <= w_rep_nxt;
            r_held        <= (w_state_nxt == ST_HELD);
            r_event_count <= r_event_count + 8'(w_evt);
        end
    end

    assign o_press       = r_press;
    assign o_release     = r_release;
    assign o_long_press  = r_long_press;
    assign o_repeat      = r_repeat;
    assign o_held        = r_held;
    assign o_event_count = r_event_count;

endmodule

// File: tb/tb_button_events.sv
// -----------------------------------------------------------------------------
// tb_button_events
//
// Directed bench for button_events with HOLD_CYCLES=4, REPEAT_CYCLES=3.
// Inputs change 1 ns after a rising edge; outputs are read at the same point,
// so each read shows the value "after" the edge just taken.
// Output vector layout: {press, release, long_press, repeat, held}.
// -----------------------------------------------------------------------------
module tb_button_events;

    logic       clk;
    logic       reset;
    logic       clean;
    logic       o_press;
    logic       o_release;
    logic       o_long_press;
    logic       o_repeat;
    logic       o_held;
    logic [7:0] o_event_count;

    int total;
    int bad;

    logic [4:0] act;
    logic [4:0] exp_v;
    logic [7:0] exp_count;

    button_events #(
        .HOLD_CYCLES  (4),
        .REPEAT_CYCLES(3),
        .CNT_WIDTH    (3)
    ) dut (
        .i_clock      (clk),
        .i_reset      (reset),
        .i_clean      (clean),
        .o_press      (o_press),
        .o_release    (o_release),
        .o_long_press (o_long_press),
        .o_repeat     (o_repeat),
        .o_held       (o_held),
        .o_event_count(o_event_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic c);
        clean = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        clean = 1'b0;
        drive(1'b0);
        drive(1'b0);
        act = {o_press, o_release, o_long_press, o_repeat, o_held};
        total++;
        if (act !== 5'b00000) begin
            bad++;
            $display("FAIL reset_outputs: got %b want %b", act, 5'b00000);
        end
        total++;
        if (o_event_count !== 8'd0) begin
            bad++;
            $display("FAIL reset_count: got %0d want 0", o_event_count);
        end
        reset = 1'b0;
        exp_count = 8'd0;
        drive(1'b0);
        drive(1'b0);
        act = {o_press, o_release, o_long_press, o_repeat, o_held};
        total++;
        if (act !== 5'b00000) begin
            bad++;
            $display("FAIL idle_after_reset: got %b want %b", act, 5'b00000);
        end
    endtask

    // clean=1 for two edges then 0: press, quiet, release.
    task automatic test_short_press;
        logic [1:0] pat [0:3];
        logic [4:0] want [0:3];
        pat[0] = 1'b1; want[0] = 5'b10000;
        pat[1] = 1'b1; want[1] = 5'b00000;
        pat[2] = 1'b0; want[2] = 5'b01000;
        pat[3] = 1'b0; want[3] = 5'b00000;
        for (int i = 0; i < 4; i++) begin
            drive(pat[i][0]);
            act = {o_press, o_release, o_long_press, o_repeat, o_held};
            total++;
            if (act !== want[i]) begin
                bad++;
                $display("FAIL short_press edge %0d: got %b want %b", i, act, want[i]);
            end
        end
        exp_count = exp_count + 8'd1;
        total++;
        if (o_event_count !== exp_count) begin
            bad++;
            $display("FAIL short_press_count: got %0d want %0d", o_event_count, exp_count);
        end
    endtask

    // clean=1 for 21 edges (i=0..20), then 0. long_press at i=4,
    // repeats at i=7,10,13,16,19, held from i=4 to i=20, release at i=21.
    task automatic test_long_hold;
        for (int i = 0; i < 22; i++) begin
            drive(i < 21 ? 1'b1 : 1'b0);
            exp_v = 5'b00000;
            if (i == 0) exp_v[4] = 1'b1;
            if (i == 21) exp_v[3] = 1'b1;
            if (i == 4) exp_v[2] = 1'b1;
            if (i == 7 || i == 10 || i == 13 || i == 16 || i == 19) exp_v[1] = 1'b1;
            if (i >= 4 && i <= 20) exp_v[0] = 1'b1;
            act = {o_press, o_release, o_long_press, o_repeat, o_held};
            total++;
            if (act !== exp_v) begin
                bad++;
                $display("FAIL long_hold edge %0d: got %b want %b", i, act, exp_v);
            end
        end
        drive(1'b0);
        exp_count = exp_count + 8'd7;
        total++;
        if (o_event_count !== exp_count) begin
            bad++;
            $display("FAIL long_hold_count: got %0d want %0d", o_event_count, exp_count);
        end
    endtask

    // Release lands on the edge where long_press would have fired.
    task automatic test_release_terminal;
        for (int i = 0; i < 6; i++) begin
            drive(i < 4 ? 1'b1 : 1'b0);
            exp_v = 5'b00000;
            if (i == 0) exp_v = 5'b10000;
            if (i == 4) exp_v = 5'b01000;
            act = {o_press, o_release, o_long_press, o_repeat, o_held};
            total++;
            if (act !== exp_v) begin
                bad++;
                $display("FAIL release_terminal edge %0d: got %b want %b", i, act, exp_v);
            end
        end
        exp_count = exp_count + 8'd1;
        total++;
        if (o_event_count !== exp_count) begin
            bad++;
            $display("FAIL release_terminal_count: got %0d want %0d", o_event_count, exp_count);
        end
    endtask

    // Reach HELD, assert reset with the button still down, then confirm that
    // nothing fires until clean goes 0 then 1.
    task automatic test_reset_mid_hold;
        for (int i = 0; i < 6; i++) drive(1'b1);
        total++;
        if (o_held !== 1'b1) begin
            bad++;
            $display("FAIL mid_hold_reached: got %b want 1", o_held);
        end
        reset = 1'b1;
        drive(1'b1);
        act = {o_press, o_release, o_long_press, o_repeat, o_held};
        total++;
        if (act !== 5'b00000 || o_event_count !== 8'd0) begin
            bad++;
            $display("FAIL mid_hold_reset: got %b/%0d want 00000/0", act, o_event_count);
        end
        drive(1'b1);
        reset = 1'b0;
        exp_count = 8'd0;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1);
            act = {o_press, o_release, o_long_press, o_repeat, o_held};
            total++;
            if (act !== 5'b00000) begin
                bad++;
                $display("FAIL held_through_reset edge %0d: got %b want 00000", i, act);
            end
        end
        drive(1'b0);
        act = {o_press, o_release, o_long_press, o_repeat, o_held};
        total++;
        if (act !== 5'b00000) begin
            bad++;
            $display("FAIL no_release_after_reset: got %b want 00000", act);
        end
        drive(1'b1);
        act = {o_press, o_release, o_long_press, o_repeat, o_held};
        total++;
        if (act !== 5'b10000) begin
            bad++;
            $display("FAIL repress_after_reset: got %b want 10000", act);
        end
        drive(1'b0);
        exp_count = exp_count + 8'd1;
        total++;
        if (o_release !== 1'b1 || o_event_count !== exp_count) begin
            bad++;
            $display("FAIL repress_release: got rel=%b cnt=%0d want rel=1 cnt=%0d",
                     o_release, o_event_count, exp_count);
        end
    endtask

    // One-cycle glitch followed by back-to-back single-cycle presses.
    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++) begin
            drive((i == 1 || i == 3 || i == 5) ? 1'b1 : 1'b0);
            exp_v = 5'b00000;
            if (i == 1 || i == 3 || i == 5) exp_v = 5'b10000;
            if (i == 2 || i == 4 || i == 6) exp_v = 5'b01000;
            act = {o_press, o_release, o_long_press, o_repeat, o_held};
            total++;
            if (act !== exp_v) begin
                bad++;
                $display("FAIL glitch edge %0d: got %b want %b", i, act, exp_v);
            end
        end
        exp_count = exp_count + 8'd3;
        total++;
        if (o_event_count !== exp_count) begin
            bad++;
            $display("FAIL glitch_count: got %0d want %0d", o_event_count, exp_count);
        end
    endtask

    task automatic test_wrap;
        reset = 1'b1;
        drive(1'b0);
        reset = 1'b0;
        drive(1'b0);
        for (int i = 0; i < 256; i++) begin
            drive(1'b1);
            drive(1'b0);
        end
        drive(1'b0);
        total++;
        if (o_event_count !== 8'd0) begin
            bad++;
            $display("FAIL wrap_256: got %0d want 0", o_event_count);
        end
        drive(1'b1);
        drive(1'b0);
        total++;
        if (o_event_count !== 8'd1) begin
            bad++;
            $display("FAIL wrap_257: got %0d want 1", o_event_count);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        clean     = 1'b0;
        exp_count = 8'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_short_press();
        test_long_hold();
        test_release_terminal();
        test_reset_mid_hold();
        test_back_to_back();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
